// File: rtl/oc8051_procarbiter_n.sv
// N-way arbiter sharing one external bus port between several oc8051 cores.
// Selection is fixed priority or round-robin. An optional watchdog releases a
// bus whose transaction never receives ack_i.
module oc8051_procarbiter_n #(
    parameter int unsigned N_PROC  = 2,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 8,
    parameter int unsigned RR      = 1,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned IW      = (N_PROC > 2) ? $clog2(N_PROC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PROC-1:0]    stb_i,
    input  logic [N_PROC-1:0]    wr_i,
    input  logic [N_PROC*AW-1:0] addr_i,
    input  logic [N_PROC*DW-1:0] wdata_i,
    input  logic [N_PROC-1:0]    priv_i,
    input  logic [N_PROC*16-1:0] dpc_i,
    output logic [N_PROC-1:0]    ack_o,
    output logic [N_PROC-1:0]    err_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 stb_o,
    output logic                 wr_o,
    output logic [AW-1:0]        addr_o,
    output logic [DW-1:0]        wdata_o,
    output logic                 priv_o,
    output logic [15:0]          dpc_o,
    input  logic                 ack_i,
    input  logic [DW-1:0]        rdata_i,
    output logic [IW-1:0]        sel_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    // Watchdog compare value; unused when the watchdog is disabled.
    localparam logic [15:0] CountLimit = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    // Start with the last-served pointer on the top core so core 0 wins first.
    localparam logic [IW-1:0] LastInit = IW'(N_PROC - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     holder_q, holder_d;
    logic [IW-1:0]     last_q, last_d;
    logic [15:0]       count_q, count_d;
    logic [N_PROC-1:0] err_q, err_d;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     sel;

    // Winner search: descending loops so the lowest qualifying index is the
    // final assignment; under round-robin, any requester above last overrides
    // the wrapped (lowest overall) candidate.
    always_comb begin
        winner = holder_q;
        for (int j = N_PROC - 1; j >= 0; j--) begin
            if (stb_i[j]) begin
                winner = IW'(j);
            end
        end
        if (RR != 0) begin
            for (int j = N_PROC - 1; j >= 0; j--) begin
                if (stb_i[j] && (j > int'(last_q))) begin
                    winner = IW'(j);
                end
            end
        end
    end

    // Bus mux: the current winner drives the bus while idle, the holder while busy.
    always_comb begin
        sel        = (state_q == StIdle) ? winner : holder_q;
        sel_o      = sel;
        stb_o      = stb_i[sel];
        wr_o       = wr_i[sel];
        priv_o     = priv_i[sel];
        addr_o     = addr_i[int'(sel)*AW +: AW];
        wdata_o    = wdata_i[int'(sel)*DW +: DW];
        dpc_o      = dpc_i[int'(sel)*16 +: 16];
        rdata_o    = rdata_i;
        ack_o      = '0;
        ack_o[sel] = ack_i;
        err_o      = err_q;
    end

    // Next-state logic for the grant FSM, pointers and watchdog.
    always_comb begin
        state_d  = state_q;
        holder_d = holder_q;
        last_d   = last_q;
        count_d  = count_q;
        err_d    = '0;
        case (state_q)
            StIdle: begin
                if (|stb_i) begin
                    holder_d = winner;
                    if (ack_i) begin
                        // Single-cycle transfer completes without entering BUSY.
                        last_d = winner;
                    end else begin
                        state_d = StBusy;
                        count_d = '0;
                    end
                end
            end
            StBusy: begin
                if (ack_i) begin
                    state_d = StIdle;
                    last_d  = holder_q;
                end else if ((TIMEOUT != 0) && (count_q == CountLimit)) begin
                    err_d[holder_q] = 1'b1;
                    state_d         = StIdle;
                    last_d          = holder_q;
                end else if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any open transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            holder_q <= '0;
            last_q   <= LastInit;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            holder_q <= holder_d;
            last_q   <= last_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_oc8051_procarbiter_n.sv
// Directed bench: a round-robin instance with a 5-cycle watchdog and a
// fixed-priority instance without watchdog, both driven by the same inputs.
module tb_oc8051_procarbiter_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stb;
    logic [3:0]  wr;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [3:0]  priv;
    logic [63:0] dpc;
    logic        ack;
    logic [7:0]  rdata;

    logic [3:0]  rr_ack_o, rr_err_o;
    logic [7:0]  rr_rdata_o, rr_wdata_o;
    logic        rr_stb_o, rr_wr_o, rr_priv_o;
    logic [15:0] rr_addr_o, rr_dpc_o;
    logic [1:0]  rr_sel_o;

    logic [3:0]  fp_ack_o, fp_err_o;
    logic [7:0]  fp_rdata_o, fp_wdata_o;
    logic        fp_stb_o, fp_wr_o, fp_priv_o;
    logic [15:0] fp_addr_o, fp_dpc_o;
    logic [1:0]  fp_sel_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    oc8051_procarbiter_n #(
        .N_PROC(4), .AW(16), .DW(8), .RR(1), .TIMEOUT(5)
    ) u_rr (
        .clk(clk), .rst(rst), .stb_i(stb), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
        .priv_i(priv), .dpc_i(dpc), .ack_o(rr_ack_o), .err_o(rr_err_o),
        .rdata_o(rr_rdata_o), .stb_o(rr_stb_o), .wr_o(rr_wr_o), .addr_o(rr_addr_o),
        .wdata_o(rr_wdata_o), .priv_o(rr_priv_o), .dpc_o(rr_dpc_o), .ack_i(ack),
        .rdata_i(rdata), .sel_o(rr_sel_o)
    );

    oc8051_procarbiter_n #(
        .N_PROC(4), .AW(16), .DW(8), .RR(0), .TIMEOUT(0)
    ) u_fp (
        .clk(clk), .rst(rst), .stb_i(stb), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
        .priv_i(priv), .dpc_i(dpc), .ack_o(fp_ack_o), .err_o(fp_err_o),
        .rdata_o(fp_rdata_o), .stb_o(fp_stb_o), .wr_o(fp_wr_o), .addr_o(fp_addr_o),
        .wdata_o(fp_wdata_o), .priv_o(fp_priv_o), .dpc_o(fp_dpc_o), .ack_i(ack),
        .rdata_i(rdata), .sel_o(fp_sel_o)
    );

    // Reset for one clock edge; returns on a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stb = 4'b0000;
        ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (rr_sel_o !== 2'd0) $display("FAIL reset_rr_sel got %0d want 0", rr_sel_o); else n_pass++;
        n_checks++; if (fp_sel_o !== 2'd0) $display("FAIL reset_fp_sel got %0d want 0", fp_sel_o); else n_pass++;
        n_checks++; if (rr_stb_o !== 1'b0) $display("FAIL reset_stb got %b want 0", rr_stb_o); else n_pass++;
        n_checks++; if (rr_ack_o !== 4'b0000) $display("FAIL reset_ack got %b want 0000", rr_ack_o); else n_pass++;
        n_checks++; if (rr_err_o !== 4'b0000) $display("FAIL reset_err got %b want 0000", rr_err_o); else n_pass++;
    endtask

    task automatic test_single_request();
        do_reset();
        stb = 4'b0100;
        #1;
        n_checks++; if (rr_sel_o !== 2'd2) $display("FAIL t1_sel got %0d want 2", rr_sel_o); else n_pass++;
        n_checks++; if (rr_addr_o !== 16'hA002) $display("FAIL t1_addr got %h want a002", rr_addr_o); else n_pass++;
        n_checks++; if (rr_wdata_o !== 8'h12) $display("FAIL t1_wdata got %h want 12", rr_wdata_o); else n_pass++;
        n_checks++; if (rr_dpc_o !== 16'hC002) $display("FAIL t1_dpc got %h want c002", rr_dpc_o); else n_pass++;
        n_checks++; if ({rr_stb_o, rr_wr_o, rr_priv_o} !== 3'b110) $display("FAIL t1_ctl got %b want 110", {rr_stb_o, rr_wr_o, rr_priv_o}); else n_pass++;
        n_checks++; if (rr_ack_o !== 4'b0000) $display("FAIL t1_ack_early got %b want 0000", rr_ack_o); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (rr_sel_o !== 2'd2) $display("FAIL t1_sel_busy got %0d want 2", rr_sel_o); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        ack = 1'b1;
        #1;
        n_checks++; if (rr_ack_o !== 4'b0100) $display("FAIL t1_ack got %b want 0100", rr_ack_o); else n_pass++;
        n_checks++; if (rr_rdata_o !== 8'h5A) $display("FAIL t1_rdata got %h want 5a", rr_rdata_o); else n_pass++;
        // Back in IDLE: a fresh request from core 0 is granted at once.
        @(negedge clk);
        ack = 1'b0;
        stb = 4'b0001;
        #1;
        n_checks++; if (rr_sel_o !== 2'd0) $display("FAIL t1_idle_sel got %0d want 0", rr_sel_o); else n_pass++;
        n_checks++; if (rr_ack_o !== 4'b0000) $display("FAIL t1_ack_once got %b want 0000", rr_ack_o); else n_pass++;
        @(negedge clk);
        ack = 1'b1;
        #1;
        n_checks++; if (rr_ack_o !== 4'b0001) $display("FAIL t1_ack0 got %b want 0001", rr_ack_o); else n_pass++;
        @(negedge clk);
        ack = 1'b0;
        stb = 4'b0000;
    endtask

    task automatic test_round_robin();
        int exp_sel[5] = '{0, 1, 2, 3, 0};
        logic [3:0] want;
        do_reset();
        stb = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ack = 1'b0;
            #1;
            n_checks++; if (rr_sel_o !== 2'(exp_sel[k])) $display("FAIL rr_sel[%0d] got %0d want %0d", k, rr_sel_o, exp_sel[k]); else n_pass++;
            @(negedge clk);
            ack = 1'b1;
            want = 4'(1 << exp_sel[k]);
            #1;
            n_checks++; if (rr_ack_o !== want) $display("FAIL rr_ack[%0d] got %b want %b", k, rr_ack_o, want); else n_pass++;
            @(negedge clk);
        end
        ack = 1'b0;
        stb = 4'b0000;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        stb = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            ack = 1'b0;
            #1;
            n_checks++; if (fp_sel_o !== 2'd0) $display("FAIL fp_sel[%0d] got %0d want 0", k, fp_sel_o); else n_pass++;
            @(negedge clk);
            ack = 1'b1;
            #1;
            n_checks++; if (fp_ack_o !== 4'b0001) $display("FAIL fp_ack[%0d] got %b want 0001", k, fp_ack_o); else n_pass++;
            @(negedge clk);
        end
        ack = 1'b0;
        stb = 4'b0000;
    endtask

    task automatic test_single_cycle();
        do_reset();
        stb = 4'b0010;
        ack = 1'b1;
        #1;
        n_checks++; if (rr_ack_o !== 4'b0010) $display("FAIL sc_ack got %b want 0010", rr_ack_o); else n_pass++;
        n_checks++; if (rr_sel_o !== 2'd1) $display("FAIL sc_sel got %0d want 1", rr_sel_o); else n_pass++;
        @(negedge clk);
        ack = 1'b0;
        stb = 4'b0101;
        #1;
        n_checks++; if (rr_sel_o !== 2'd2) $display("FAIL sc_next_sel got %0d want 2", rr_sel_o); else n_pass++;
        @(negedge clk);
        ack = 1'b1;
        #1;
        n_checks++; if (rr_ack_o !== 4'b0100) $display("FAIL sc_next_ack got %b want 0100", rr_ack_o); else n_pass++;
        @(negedge clk);
        ack = 1'b0;
        stb = 4'b0000;
    endtask

    task automatic test_watchdog();
        do_reset();
        stb = 4'b0010;
        #1;
        n_checks++; if (rr_sel_o !== 2'd1) $display("FAIL wd_sel got %0d want 1", rr_sel_o); else n_pass++;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            stb = 4'b1010;
            #1;
            n_checks++; if (rr_err_o !== 4'b0000) $display("FAIL wd_err_early[%0d] got %b want 0000", c, rr_err_o); else n_pass++;
            n_checks++; if (rr_sel_o !== 2'd1) $display("FAIL wd_hold[%0d] got %0d want 1", c, rr_sel_o); else n_pass++;
        end
        @(negedge clk); #1;
        n_checks++; if (rr_err_o !== 4'b0010) $display("FAIL wd_err got %b want 0010", rr_err_o); else n_pass++;
        n_checks++; if (rr_sel_o !== 2'd3) $display("FAIL wd_regrant got %0d want 3", rr_sel_o); else n_pass++;
        n_checks++; if (fp_err_o !== 4'b0000) $display("FAIL wd_disabled got %b want 0000", fp_err_o); else n_pass++;
        @(negedge clk);
        ack = 1'b1;
        #1;
        n_checks++; if (rr_err_o !== 4'b0000) $display("FAIL wd_err_pulse got %b want 0000", rr_err_o); else n_pass++;
        n_checks++; if (rr_ack_o !== 4'b1000) $display("FAIL wd_ack3 got %b want 1000", rr_ack_o); else n_pass++;
        @(negedge clk);
        ack = 1'b0;
        stb = 4'b0000;

        // Ack on the last allowed BUSY cycle wins over the timeout.
        do_reset();
        stb = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
        end
        @(negedge clk);
        ack = 1'b1;
        #1;
        n_checks++; if (rr_ack_o !== 4'b0010) $display("FAIL wd_ack_edge got %b want 0010", rr_ack_o); else n_pass++;
        @(negedge clk);
        ack = 1'b0;
        stb = 4'b0000;
        #1;
        n_checks++; if (rr_err_o !== 4'b0000) $display("FAIL wd_no_err got %b want 0000", rr_err_o); else n_pass++;
        n_checks++; if (rr_sel_o !== 2'd1) $display("FAIL wd_idle_holder got %0d want 1", rr_sel_o); else n_pass++;
    endtask

    task automatic test_reset_busy();
        do_reset();
        stb = 4'b0100;
        @(negedge clk);
        stb = 4'b1100;
        #1;
        n_checks++; if (rr_sel_o !== 2'd2) $display("FAIL rb_busy_sel got %0d want 2", rr_sel_o); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stb = 4'b0000;
        #1;
        n_checks++; if (rr_err_o !== 4'b0000) $display("FAIL rb_err got %b want 0000", rr_err_o); else n_pass++;
        n_checks++; if (rr_sel_o !== 2'd0) $display("FAIL rb_holder got %0d want 0", rr_sel_o); else n_pass++;
        n_checks++; if (rr_stb_o !== 1'b0) $display("FAIL rb_stb got %b want 0", rr_stb_o); else n_pass++;
        @(negedge clk);
        stb = 4'b1100;
        ack = 1'b1;
        #1;
        n_checks++; if (rr_sel_o !== 2'd2) $display("FAIL rb_regrant got %0d want 2", rr_sel_o); else n_pass++;
        n_checks++; if (rr_ack_o !== 4'b0100) $display("FAIL rb_ack got %b want 0100", rr_ack_o); else n_pass++;
        @(negedge clk);
        ack = 1'b0;
        stb = 4'b0000;
    endtask

    initial begin
        rst   = 1'b1;
        stb   = 4'b0000;
        ack   = 1'b0;
        wr    = 4'b0101;
        priv  = 4'b1010;
        rdata = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            addr[k*16 +: 16] = 16'hA000 + 16'(k);
            wdata[k*8 +: 8]  = 8'h10 + 8'(k);
            dpc[k*16 +: 16]  = 16'hC000 + 16'(k);
        end
        test_reset();
        test_single_request();
        test_round_robin();
        test_fixed_priority();
        test_single_cycle();
        test_watchdog();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
